led_rate_regs: RTL and testbench

Memory-mapped register block that lets the softcore CPU program per-LED blink periods. It is a bus slave on the peripheral bus. Each LED rate is written to a shadow register, then applied atomically to the active registers on a commit. The active values drive the 16-bit millisecond blink-rate inputs of the per-LED blinker instances on the Nexys4 DDR top level.

---
 rtl/led_rate_regs_pkg.sv | 20 ++
 rtl/led_rate_regs.sv | 136 +++++++++++++
 tb/tb_led_rate_regs.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/led_rate_regs_pkg.sv
// Shared constants for the LED blink-rate register block: register map,
// CTRL bit positions, rate field width and the bus FSM state encoding.
package led_pkg;

  localparam int ADDR_CTRL      = 0;
  localparam int ADDR_STATUS    = 1;
  localparam int ADDR_RATE_BASE = 2;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_COMMIT = 1;
  localparam int CTRL_AUTO   = 2;

  localparam int LED_RATE_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/led_rate_regs.sv
// Peripheral-bus register slave holding per-LED blink rates: shadow copies
// written by the CPU, active copies applied on commit (or immediately in AUTO).
module led_rate_regs
  import led_pkg::*;
#(
  parameter int NUM_LEDS = 16,
  parameter int ADDR_W   = 8,
  parameter int RATE_W   = LED_RATE_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       bus_req,
  input  logic                       bus_we,
  input  logic [ADDR_W-1:0]          bus_addr,
  input  logic [31:0]                bus_wdata,
  output logic [31:0]                bus_rdata,
  output logic                       bus_ack,
  output logic                       bus_err,
  output logic [NUM_LEDS*RATE_W-1:0] led_blink_rate_ms,
  output logic                       commit_pending
);

  localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  bus_state_e state, state_nxt;

  logic [NUM_LEDS-1:0][RATE_W-1:0] shadow;
  logic [NUM_LEDS-1:0][RATE_W-1:0] active;
  logic                            en, auto;

  logic              accept, wr_fire;
  logic              hit_ctrl, hit_status, hit_rate;
  logic [ADDR_W-1:0] idx;
  logic [IDX_W-1:0]  idx_sel;
  logic              commit_fire;
  logic [31:0]       rd_nxt;
  logic              err_nxt;
  logic              unused_bits;

  // ---------------------------------------------------------------- decode
  assign accept     = (state == IDLE) && bus_req;
  assign wr_fire    = accept && bus_we;
  assign idx        = bus_addr - ADDR_W'(ADDR_RATE_BASE);
  assign idx_sel    = idx[IDX_W-1:0];
  assign hit_ctrl   = (bus_addr == ADDR_W'(ADDR_CTRL));
  assign hit_status = (bus_addr == ADDR_W'(ADDR_STATUS));
  assign hit_rate   = (bus_addr >= ADDR_W'(ADDR_RATE_BASE)) && (idx < ADDR_W'(NUM_LEDS));

  assign commit_fire = wr_fire && hit_ctrl && bus_wdata[CTRL_COMMIT];
  assign unused_bits = ^{bus_wdata, idx};

  // ---------------------------------------------------------------- bus FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus_req) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_ack = (state == ACK);
  end

  // ---------------------------------------------------------------- read path
  always_comb begin
    rd_nxt  = '0;
    err_nxt = 1'b0;
    if (hit_ctrl) begin
      rd_nxt[CTRL_EN]   = en;
      rd_nxt[CTRL_AUTO] = auto;
    end else if (hit_status) begin
      rd_nxt[0] = commit_pending;
    end else if (hit_rate) begin
      rd_nxt[RATE_W-1:0] = shadow[idx_sel];
    end else begin
      err_nxt = 1'b1;
    end
  end

  // Read data is captured at the accepting edge so it is stable for the ack cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_rdata <= '0;
      bus_err   <= 1'b0;
    end else if (accept) begin
      bus_rdata <= bus_we ? 32'h0 : rd_nxt;
      bus_err   <= err_nxt;
    end
  end

  // ---------------------------------------------------------------- CTRL / STATUS
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en   <= 1'b0;
      auto <= 1'b0;
    end else if (wr_fire && hit_ctrl) begin
      en   <= bus_wdata[CTRL_EN];
      auto <= bus_wdata[CTRL_AUTO];
    end
  end

  // Pending only tracks shadow writes that have not reached the active set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             commit_pending <= 1'b0;
    else if (commit_fire)                  commit_pending <= 1'b0;
    else if (wr_fire && hit_rate && !auto) commit_pending <= 1'b1;
  end

  // ---------------------------------------------------------------- per-LED regs
  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_led
    logic rate_wr;
    assign rate_wr = wr_fire && hit_rate && (idx_sel == IDX_W'(g));

    always_ff @(posedge clk or posedge reset) begin
      if (reset)        shadow[g] <= '0;
      else if (rate_wr) shadow[g] <= bus_wdata[RATE_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset)                active[g] <= '0;
      else if (commit_fire)     active[g] <= shadow[g];
      else if (rate_wr && auto) active[g] <= bus_wdata[RATE_W-1:0];
    end

    // Disabled output reads as zero (LED off) while the active value is kept.
    assign led_blink_rate_ms[g*RATE_W +: RATE_W] = en ? active[g] : '0;
  end

endmodule

// File: tb/tb_led_rate_regs.sv
// Directed test of led_rate_regs: bus transactions are scored against
// expected responses queued at issue time; output side effects checked at ack.
module tb_led_rate_regs;
  localparam int NUM_LEDS = 16;
  localparam int ADDR_W   = 8;
  localparam int RATE_W   = 16;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       bus_req;
  logic                       bus_we;
  logic [ADDR_W-1:0]          bus_addr;
  logic [31:0]                bus_wdata;
  logic [31:0]                bus_rdata;
  logic                       bus_ack;
  logic                       bus_err;
  logic [NUM_LEDS*RATE_W-1:0] led_blink_rate_ms;
  logic                       commit_pending;

  led_rate_regs #(.NUM_LEDS(NUM_LEDS), .ADDR_W(ADDR_W), .RATE_W(RATE_W)) dut (
    .clk(clk), .reset(reset), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .bus_err(bus_err),
    .led_blink_rate_ms(led_blink_rate_ms), .commit_pending(commit_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        is_rd;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RATE_W-1:0] led(input int i);
    return led_blink_rate_ms[i*RATE_W +: RATE_W];
  endfunction

  // Issues one transaction; returns at the negedge inside the ack cycle.
  task automatic txn(input string tag, input logic we, input logic [ADDR_W-1:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    exp_t got;
    int   n;
    e.tag = tag; e.is_rd = !we; e.rdata = exp_rd; e.err = exp_err;
    exp_q.push_back(e);
    @(negedge clk);
    bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_ack && n < 8);
    chk({tag, "_latency"}, 64'(n), 64'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      got = exp_q.pop_front();
      chk({got.tag, "_err"}, 64'(bus_err), 64'(got.err));
      if (got.is_rd) chk({got.tag, "_rdata"}, 64'(bus_rdata), 64'(got.rdata));
    end
    bus_req = 1'b0; bus_we = 1'b0;
  endtask

  initial begin
    int acks;
    logic prev_ack;
    bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;

    // 1. reset
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ack", 64'(bus_ack), 64'd0);
    chk("rst_led", 64'(led_blink_rate_ms == '0), 64'd1);
    chk("rst_pending", 64'(commit_pending), 64'd0);
    reset = 1'b0;
    txn("rd_ctrl0", 1'b0, 8'h00, 32'h0, 32'h0, 1'b0);
    txn("rd_stat0", 1'b0, 8'h01, 32'h0, 32'h0, 1'b0);
    txn("rd_rate0", 1'b0, 8'h02, 32'h0, 32'h0, 1'b0);

    // 2. shadow then commit
    txn("wr_ctrl_en", 1'b1, 8'h00, 32'h1, 32'h0, 1'b0);
    txn("wr_rate3", 1'b1, 8'h05, 32'd500, 32'h0, 1'b0);
    chk("led3_shadow_only", 64'(led(3)), 64'd0);
    chk("pending_set", 64'(commit_pending), 64'd1);
    txn("rd_rate3", 1'b0, 8'h05, 32'h0, 32'd500, 1'b0);
    txn("rd_stat1", 1'b0, 8'h01, 32'h0, 32'h1, 1'b0);
    txn("wr_commit", 1'b1, 8'h00, 32'h3, 32'h0, 1'b0);
    chk("led3_commit", 64'(led(3)), 64'd500);
    chk("pending_clr", 64'(commit_pending), 64'd0);
    txn("rd_ctrl_commit0", 1'b0, 8'h00, 32'h0, 32'h1, 1'b0);

    // 3. auto-commit, upper data bits dropped
    txn("wr_ctrl_auto", 1'b1, 8'h00, 32'h5, 32'h0, 1'b0);
    txn("wr_rate0_auto", 1'b1, 8'h02, 32'hABCDFFFF, 32'h0, 1'b0);
    chk("led0_auto", 64'(led(0)), 64'hFFFF);
    chk("pending_auto", 64'(commit_pending), 64'd0);
    txn("rd_rate0_trunc", 1'b0, 8'h02, 32'h0, 32'h0000FFFF, 1'b0);
    txn("rd_ctrl_auto", 1'b0, 8'h00, 32'h0, 32'h5, 1'b0);

    // 4. enable gating
    txn("wr_ctrl_off", 1'b1, 8'h00, 32'h0, 32'h0, 1'b0);
    chk("led_gated", 64'(led_blink_rate_ms == '0), 64'd1);
    txn("wr_ctrl_on", 1'b1, 8'h00, 32'h1, 32'h0, 1'b0);
    chk("led3_restored", 64'(led(3)), 64'd500);
    chk("led0_restored", 64'(led(0)), 64'hFFFF);

    // 5. unmapped and handshake
    txn("rd_unmapped", 1'b0, 8'(2 + NUM_LEDS), 32'h0, 32'h0, 1'b1);
    txn("wr_unmapped", 1'b1, 8'h40, 32'h1234, 32'h0, 1'b1);
    chk("led3_after_unmapped", 64'(led(3)), 64'd500);
    txn("rd_last_rate", 1'b0, 8'(1 + NUM_LEDS), 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 8'h01;
    acks = 0; prev_ack = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus_ack) acks++;
      chk("hold_no_b2b", 64'(prev_ack && bus_ack), 64'd0);
      prev_ack = bus_ack;
    end
    chk("hold_ack_count", 64'(acks), 64'd4);
    bus_req = 1'b0;
    @(negedge clk);

    // 6. reset in the ack cycle
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = 8'h03; bus_wdata = 32'd100;
    @(negedge clk);
    chk("mid_ack_seen", 64'(bus_ack), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_ack_drop", 64'(bus_ack), 64'd0);
    chk("mid_led_clr", 64'(led_blink_rate_ms == '0), 64'd0 + 64'd1);
    bus_req = 1'b0; bus_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    txn("rd_rate1_after_rst", 1'b0, 8'h03, 32'h0, 32'h0, 1'b0);
    txn("rd_rate3_after_rst", 1'b0, 8'h05, 32'h0, 32'h0, 1'b0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
